// File: rtl/mips_register_file_pkg.sv
// Shared definitions for the MIPS general-purpose register file.
package mips_register_file_pkg;

  localparam int         REG_COUNT = 32;
  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam logic [4:0] REG_V0    = 5'd2;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_index_t;

endpackage

// File: rtl/mips_register_file_if.sv
// Operand read, writeback and $v0 tap signals between the datapath and the register file.
interface mips_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic [ADDR_WIDTH-1:0] a1;
  logic [ADDR_WIDTH-1:0] a2;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic [ADDR_WIDTH-1:0] write_index3;
  logic [DATA_WIDTH-1:0] write_data3;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] register_v0;

  modport master (
    output a1, a2, write_index3, write_data3, write_enable,
    input  read_data1, read_data2, register_v0
  );

  modport slave (
    input  a1, a2, write_index3, write_data3, write_enable,
    output read_data1, read_data2, register_v0
  );

endinterface

// File: rtl/mips_register_file.sv
// 32 x 32 register file: two asynchronous read ports, one clocked write port, r0 fixed at zero.
module mips_register_file
  import mips_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_register_file_if.slave   rf
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] regs_d [NREGS];

  // r0 is never loaded, so it holds the reset zero forever.
  always_comb begin
    regs_d = regs_q;
    if (rf.write_enable && (rf.write_index3 != '0)) begin
      regs_d[rf.write_index3] = rf.write_data3;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write-to-read forwarding; the pipeline provides bypass.
  assign rf.read_data1  = (rf.a1 == '0) ? '0 : regs_q[rf.a1];
  assign rf.read_data2  = (rf.a2 == '0) ? '0 : regs_q[rf.a2];
  assign rf.register_v0 = regs_q[ADDR_WIDTH'(REG_V0)];

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: expected read values queued at stimulus, checked at output.
module tb_mips_register_file;

  logic clk;
  logic reset;

  mips_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

  mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : model[idx];
  endfunction

  task automatic model_edge(input logic rst_n, input logic we, input logic [4:0] idx,
                            input logic [31:0] d);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (we && idx != 5'd0) begin
      model[idx] = d;
    end
  endtask

  // Queue expectations for the current addresses, let outputs settle, then pop and compare.
  task automatic read_check(input string tag, input logic [4:0] ra1, input logic [4:0] ra2);
    exp_t e;
    rf.a1 = ra1;
    rf.a2 = ra2;
    e.tag = {tag, "_rd1"}; e.exp = model_rd(ra1); sb.push_back(e);
    e.tag = {tag, "_rd2"}; e.exp = model_rd(ra2); sb.push_back(e);
    e.tag = {tag, "_v0"};  e.exp = model[2];      sb.push_back(e);
    #1;
    e = sb.pop_front(); chk(e.tag, rf.read_data1, e.exp);
    e = sb.pop_front(); chk(e.tag, rf.read_data2, e.exp);
    e = sb.pop_front(); chk(e.tag, rf.register_v0, e.exp);
  endtask

  task automatic do_edge(input logic rst_n, input logic we, input logic [4:0] idx,
                         input logic [31:0] d);
    @(negedge clk);
    reset           = rst_n;
    rf.write_enable = we;
    rf.write_index3 = idx;
    rf.write_data3  = d;
    @(posedge clk);
    model_edge(rst_n, we, idx, d);
    #1;
    reset           = 1'b1;
    rf.write_enable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'hxxxx_xxxx;
    reset           = 1'b0;
    rf.a1           = '0;
    rf.a2           = '0;
    rf.write_index3 = '0;
    rf.write_data3  = '0;
    rf.write_enable = 1'b0;

    // 1. reset with write_enable low, sweep every index
    do_edge(1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 32; i++) read_check($sformatf("reset_r%0d", i), 5'(i), 5'(31 - i));

    // 2. basic write/read
    do_edge(1'b1, 1'b1, 5'd1, 32'd3);
    read_check("wr_r1", 5'd1, 5'd0);

    // 3. second register, then move a2 combinationally
    do_edge(1'b1, 1'b1, 5'd2, 32'd10);
    read_check("wr_r2_keep", 5'd1, 5'd0);
    read_check("wr_r2_a2", 5'd1, 5'd2);

    // 4. write-enable gating
    do_edge(1'b1, 1'b0, 5'd2, 32'd5);
    read_check("we_gate", 5'd1, 5'd2);

    // 5. zero register
    do_edge(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
    read_check("r0_write", 5'd0, 5'd0);

    // 6a. reset beats a simultaneous write
    do_edge(1'b1, 1'b1, 5'd1, 32'd3);
    do_edge(1'b0, 1'b1, 5'd1, 32'd7);
    read_check("rst_prio", 5'd1, 5'd2);

    // 6b. read-during-write: old value before the edge, new value after
    do_edge(1'b1, 1'b1, 5'd4, 32'h0000_0011);
    @(negedge clk);
    rf.write_enable = 1'b1;
    rf.write_index3 = 5'd4;
    rf.write_data3  = 32'h0000_0055;
    read_check("rdw_before", 5'd4, 5'd4);
    @(posedge clk);
    model_edge(1'b1, 1'b1, 5'd4, 32'h0000_0055);
    #1;
    rf.write_enable = 1'b0;
    read_check("rdw_after", 5'd4, 5'd4);

    // random writes (including disabled and r0) with mixed reads
    for (int k = 0; k < 40; k++) begin
      do_edge(1'b1, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
      read_check($sformatf("rand%0d", k), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    read_check("rand_v0", 5'd2, 5'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
